// File: rtl/rom_load_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom_load_pkg
//  Description : Shared types and constants for the ROM download controller
//                and its region decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package rom_load_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

    // Region indices into the one-hot write-enable vector
    localparam int REG_CPU  = 0;
    localparam int REG_SND  = 1;
    localparam int REG_TILE = 2;
    localparam int REG_SPR  = 3;

    localparam int NUM_REGIONS = 4;

    // Default exclusive region ends (Burger Time image layout)
    localparam logic [16:0] DEF_R0_END = 17'h0A000;
    localparam logic [16:0] DEF_R1_END = 17'h0B000;
    localparam logic [16:0] DEF_R2_END = 17'h11000;
    localparam logic [16:0] DEF_R3_END = 17'h17000;

    localparam logic [17:0] BYTE_COUNT_MAX = 18'h3FFFF;

    // Increment that sticks at the top of the counter range
    function automatic logic [17:0] sat_inc(input logic [17:0] value);
        return (value == BYTE_COUNT_MAX) ? value : value + 18'd1;
    endfunction

endpackage : rom_load_pkg
`default_nettype wire

// File: rtl/rom_region_decode.sv
`default_nettype none
// ============================================================================
//  Module      : rom_region_decode
//  Description : Combinational map from a download byte address to a ROM
//                region (one-hot) and a region-relative offset.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_region_decode
    import rom_load_pkg::*;
#(
    parameter logic [16:0] R0_END = DEF_R0_END,
    parameter logic [16:0] R1_END = DEF_R1_END,
    parameter logic [16:0] R2_END = DEF_R2_END,
    parameter logic [16:0] R3_END = DEF_R3_END
) (
    input  logic [24:0]            addr,
    output logic                   valid,
    output logic [NUM_REGIONS-1:0] sel,
    output logic [16:0]            offset
);

    logic [16:0] low_addr;
    logic        upper_zero;

    assign low_addr   = addr[16:0];
    assign upper_zero = (addr[24:17] == 8'd0);

    // First region whose end lies above the address wins; anything past the
    // last region or with upper address bits set is not a ROM byte.
    always_comb begin
        valid  = 1'b0;
        sel    = '0;
        offset = '0;
        if (upper_zero) begin
            if (low_addr < R0_END) begin
                valid        = 1'b1;
                sel[REG_CPU] = 1'b1;
                offset       = low_addr;
            end else if (low_addr < R1_END) begin
                valid        = 1'b1;
                sel[REG_SND] = 1'b1;
                offset       = low_addr - R0_END;
            end else if (low_addr < R2_END) begin
                valid         = 1'b1;
                sel[REG_TILE] = 1'b1;
                offset        = low_addr - R1_END;
            end else if (low_addr < R3_END) begin
                valid        = 1'b1;
                sel[REG_SPR] = 1'b1;
                offset       = low_addr - R2_END;
            end
        end
    end

endmodule : rom_region_decode
`default_nettype wire

// File: rtl/rom_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rom_load_ctrl
//  Description : Sequences the HPS ROM download into the arcade core: region
//                write strobes, image length validation, and core reset
//                hold/stretch until a valid image has settled.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_load_ctrl
    import rom_load_pkg::*;
#(
    parameter logic [16:0] R0_END        = DEF_R0_END,
    parameter logic [16:0] R1_END        = DEF_R1_END,
    parameter logic [16:0] R2_END        = DEF_R2_END,
    parameter logic [16:0] R3_END        = DEF_R3_END,
    parameter int          SETTLE_CYCLES = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        reset_req,
    output logic [3:0]  rom_we,
    output logic [16:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        core_reset,
    output logic        load_done,
    output logic        load_error,
    output logic [17:0] byte_count
);

    localparam logic [7:0]  SETTLE_RELOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [17:0] IMAGE_LEN     = {1'b0, R3_END};

    state_t      state, state_n;
    logic        dl_q;
    logic        ovf, ovf_n;
    logic [7:0]  settle_cnt, settle_cnt_n;

    logic [3:0]  rom_we_n;
    logic [16:0] rom_addr_n;
    logic [7:0]  rom_data_n;
    logic [17:0] byte_count_n;
    logic        load_done_n;
    logic        load_error_n;
    logic        core_reset_n;

    logic        dl_rise, dl_fall;
    logic        wr_accept;
    logic        dec_valid;
    logic [3:0]  dec_sel;
    logic [16:0] dec_offset;

    assign dl_rise = ioctl_download & ~dl_q;
    assign dl_fall = ~ioctl_download & dl_q;

    rom_region_decode #(
        .R0_END (R0_END),
        .R1_END (R1_END),
        .R2_END (R2_END),
        .R3_END (R3_END)
    ) u_decode (
        .addr   (ioctl_addr),
        .valid  (dec_valid),
        .sel    (dec_sel),
        .offset (dec_offset)
    );

    // Next-state, byte acceptance and registered-output next values
    always_comb begin
        state_n      = state;
        settle_cnt_n = settle_cnt;
        ovf_n        = ovf;
        byte_count_n = byte_count;
        rom_we_n     = '0;
        rom_addr_n   = rom_addr;
        rom_data_n   = rom_data;
        load_done_n  = load_done;

        // A strobe landing on the falling edge of download still belongs to
        // the image, so it is accepted before the length compare below.
        wr_accept = (state == ST_LOAD) && ioctl_wr && (ioctl_download || dl_fall);

        if (wr_accept) begin
            if (dec_valid) begin
                rom_we_n     = dec_sel;
                rom_addr_n   = dec_offset;
                rom_data_n   = ioctl_dout;
                byte_count_n = sat_inc(byte_count);
            end else begin
                ovf_n = 1'b1;
            end
        end

        if (dl_rise && (state != ST_LOAD)) begin
            state_n      = ST_LOAD;
            byte_count_n = '0;
            ovf_n        = 1'b0;
            load_done_n  = 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (dl_fall) begin
                        if ((byte_count_n == IMAGE_LEN) && !ovf_n) begin
                            state_n      = ST_SETTLE;
                            settle_cnt_n = SETTLE_RELOAD;
                        end else begin
                            state_n = ST_FAIL;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (reset_req) begin
                        settle_cnt_n = SETTLE_RELOAD;
                    end else if (settle_cnt == 8'd0) begin
                        state_n = ST_RUN;
                    end else begin
                        settle_cnt_n = settle_cnt - 8'd1;
                    end
                end
                ST_RUN: begin
                    if (reset_req) begin
                        state_n      = ST_SETTLE;
                        settle_cnt_n = SETTLE_RELOAD;
                    end
                end
                default: begin
                    // IDLE and FAIL only leave on a new download
                end
            endcase
        end

        if (state_n == ST_RUN) begin
            load_done_n = 1'b1;
        end
        if (state_n == ST_FAIL) begin
            load_done_n = 1'b0;
        end
        load_error_n = (state_n == ST_FAIL);
        core_reset_n = (state_n != ST_RUN);
    end

    // State register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath and output registers; reset drops any pending write strobe
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_q       <= 1'b0;
            ovf        <= 1'b0;
            settle_cnt <= '0;
            rom_we     <= '0;
            rom_addr   <= '0;
            rom_data   <= '0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            byte_count <= '0;
        end else begin
            dl_q       <= ioctl_download;
            ovf        <= ovf_n;
            settle_cnt <= settle_cnt_n;
            rom_we     <= rom_we_n;
            rom_addr   <= rom_addr_n;
            rom_data   <= rom_data_n;
            core_reset <= core_reset_n;
            load_done  <= load_done_n;
            load_error <= load_error_n;
            byte_count <= byte_count_n;
        end
    end

endmodule : rom_load_ctrl
`default_nettype wire
